// File: rtl/facto_slave_regs.sv
// facto_slave_regs
//   Bus-slave register block for the factorial accelerator. Holds the
//   control registers, runs the IDLE/BUSY/DONE sequencer, captures the
//   core result on completion and drives a maskable interrupt.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset_n        synchronous active-low reset
//   s_sel/s_wr     slave select / 1=write 0=read
//   s_addr         byte offset, word index = s_addr[OFF_W-1:3]
//   s_din/s_dout   write data / registered read data (1-cycle latency)
//   op_start       one-cycle start pulse to the core
//   op_clear       one-cycle clear pulse to the core
//   operand        OPERAND register contents
//   core_done      core completion pulse, results valid in the same cycle
//   core_result_h/l  result words from the core
//   interrupt      registered INTREN[0] & done
//
// Word map: 0 OPSTART(W) 1 OPCLEAR(W) 2 OPDONE(RO) 3 INTREN(RW)
//           4 OPERAND(RW) 5 RESULT_H(RO) 6 RESULT_L(RO)
//
// state | meaning
// IDLE  | no operation pending, done=0
// BUSY  | core computing, operand writes and start requests ignored
// DONE  | result captured, done=1
module facto_slave_regs #(
  parameter int DATA_W = 64,
  parameter int OFF_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [OFF_W-1:0]  s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              op_start,
  output logic              op_clear,
  output logic [DATA_W-1:0] operand,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result_h,
  input  logic [DATA_W-1:0] core_result_l,
  output logic              interrupt
);

  localparam int IDX_W = OFF_W - 3;
  localparam logic [IDX_W-1:0] W_OPSTART  = IDX_W'(0);
  localparam logic [IDX_W-1:0] W_OPCLEAR  = IDX_W'(1);
  localparam logic [IDX_W-1:0] W_OPDONE   = IDX_W'(2);
  localparam logic [IDX_W-1:0] W_INTREN   = IDX_W'(3);
  localparam logic [IDX_W-1:0] W_OPERAND  = IDX_W'(4);
  localparam logic [IDX_W-1:0] W_RESULT_H = IDX_W'(5);
  localparam logic [IDX_W-1:0] W_RESULT_L = IDX_W'(6);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] result_h_q, result_h_d;
  logic [DATA_W-1:0] result_l_q, result_l_d;
  logic [DATA_W-1:0] operand_q;
  logic [DATA_W-1:0] s_dout_q;
  logic              intren_q;
  logic              op_start_q, op_clear_q, interrupt_q;
  logic              start_pulse, clear_pulse;
  logic [DATA_W-1:0] rd_data;

  logic [IDX_W-1:0] widx;
  logic             wr_en, rd_en, start_req, clear_req;
  logic             unused_addr_lsb;

  assign widx            = s_addr[OFF_W-1:3];
  assign unused_addr_lsb = ^s_addr[2:0];
  assign wr_en           = s_sel & s_wr;
  assign rd_en           = s_sel & ~s_wr;
  assign start_req       = wr_en & (widx == W_OPSTART) & s_din[0];
  assign clear_req       = wr_en & (widx == W_OPCLEAR) & s_din[0];

  // Clear takes priority over everything, including a coincident core_done.
  always_comb begin
    state_d     = state_q;
    result_h_d  = result_h_q;
    result_l_d  = result_l_q;
    start_pulse = 1'b0;
    clear_pulse = 1'b0;
    if (clear_req) begin
      state_d     = S_IDLE;
      result_h_d  = '0;
      result_l_d  = '0;
      clear_pulse = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_req) begin
            state_d     = S_BUSY;
            start_pulse = 1'b1;
          end
        end
        S_BUSY: begin
          if (core_done) begin
            state_d    = S_DONE;
            result_h_d = core_result_h;
            result_l_d = core_result_l;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (widx)
      W_OPDONE:   rd_data = DATA_W'({state_q == S_BUSY, state_q == S_DONE});
      W_INTREN:   rd_data = DATA_W'(intren_q);
      W_OPERAND:  rd_data = operand_q;
      W_RESULT_H: rd_data = result_h_q;
      W_RESULT_L: rd_data = result_l_q;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      result_h_q  <= '0;
      result_l_q  <= '0;
      operand_q   <= '0;
      intren_q    <= 1'b0;
      s_dout_q    <= '0;
      op_start_q  <= 1'b0;
      op_clear_q  <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_h_q  <= result_h_d;
      result_l_q  <= result_l_d;
      op_start_q  <= start_pulse;
      op_clear_q  <= clear_pulse;
      s_dout_q    <= rd_en ? rd_data : '0;
      // Uses pre-edge state, so it follows DONE entry/exit by one cycle.
      interrupt_q <= intren_q & (state_q == S_DONE);
      if (wr_en && (widx == W_INTREN)) begin
        intren_q <= s_din[0];
      end
      if (wr_en && (widx == W_OPERAND) && (state_q != S_BUSY)) begin
        operand_q <= s_din;
      end
    end
  end

  assign s_dout    = s_dout_q;
  assign op_start  = op_start_q;
  assign op_clear  = op_clear_q;
  assign operand   = operand_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_facto_slave_regs.sv
module tb_facto_slave_regs;
  localparam int DW = 64;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_sel, s_wr;
  logic [OW-1:0] s_addr;
  logic [DW-1:0] s_din, s_dout;
  logic          op_start, op_clear, interrupt;
  logic [DW-1:0] operand;
  logic          core_done;
  logic [DW-1:0] core_result_h, core_result_l;

  int n_checks = 0;
  int n_pass   = 0;

  facto_slave_regs #(.DATA_W(DW), .OFF_W(OW)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout),
    .op_start(op_start), .op_clear(op_clear), .operand(operand),
    .core_done(core_done), .core_result_h(core_result_h), .core_result_l(core_result_l),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: register contents and an operation-status view.
  bit            m_valid = 0;
  bit            m_busy, m_done, m_intren;
  logic [DW-1:0] m_operand, m_rh, m_rl;
  logic [DW-1:0] e_dout;
  bit            e_start, e_clear, e_irq;

  function automatic logic [DW-1:0] model_read(int idx);
    case (idx)
      2: return {62'd0, m_busy, m_done};
      3: return {63'd0, m_intren};
      4: return m_operand;
      5: return m_rh;
      6: return m_rl;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    int  idx;
    bit  wr, rd, was_busy;
    if (!reset_n) begin
      m_valid = 1; m_busy = 0; m_done = 0; m_intren = 0;
      m_operand = '0; m_rh = '0; m_rl = '0;
      e_dout = '0; e_start = 0; e_clear = 0; e_irq = 0;
    end else if (m_valid) begin
      idx      = int'(s_addr[OW-1:3]);
      wr       = s_sel && s_wr;
      rd       = s_sel && !s_wr;
      was_busy = m_busy;
      e_dout   = rd ? model_read(idx) : '0;
      e_irq    = m_intren && m_done;
      e_start  = 0;
      e_clear  = 0;
      if (wr && idx == 1 && s_din[0]) begin
        m_busy = 0; m_done = 0; m_rh = '0; m_rl = '0; e_clear = 1;
      end else if (wr && idx == 0 && s_din[0] && !was_busy) begin
        m_busy = 1; m_done = 0; e_start = 1;
      end else if (was_busy && core_done) begin
        m_busy = 0; m_done = 1; m_rh = core_result_h; m_rl = core_result_l;
      end
      if (wr && idx == 3) m_intren = s_din[0];
      if (wr && idx == 4 && !was_busy) m_operand = s_din;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("s_dout",    s_dout,          e_dout);
      chk("op_start",  DW'(op_start),   DW'(e_start));
      chk("op_clear",  DW'(op_clear),   DW'(e_clear));
      chk("operand",   operand,         m_operand);
      chk("interrupt", DW'(interrupt),  DW'(e_irq));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    s_sel = 0; s_wr = 0; s_addr = '0; s_din = '0;
  endtask

  // Low address bits are deliberately nonzero to confirm they are ignored.
  task automatic wr(input int idx, input logic [DW-1:0] d);
    s_sel = 1; s_wr = 1; s_addr = {5'(idx), 3'(idx + 1)}; s_din = d;
    tick();
    idle();
  endtask

  task automatic rd(input int idx, input string name, input logic [DW-1:0] exp);
    s_sel = 1; s_wr = 0; s_addr = {5'(idx), 3'(7 - idx)}; s_din = '1;
    tick();
    idle();
    chk(name, s_dout, exp);
  endtask

  task automatic core(input logic [DW-1:0] h, input logic [DW-1:0] l);
    core_done = 1; core_result_h = h; core_result_l = l;
    tick();
    core_done = 0; core_result_h = '0; core_result_l = '0;
  endtask

  initial begin
    reset_n = 0; core_done = 0; core_result_h = '0; core_result_l = '0;
    idle();
    tick(); tick();
    reset_n = 1;
    chk("rst_dout", s_dout, 0);
    chk("rst_irq", DW'(interrupt), 0);
    rd(2, "opdone_rst", 0);
    rd(7, "word7", 0);
    chk("irq_idle", DW'(interrupt), 0);

    wr(4, 5);
    wr(3, 1);
    wr(0, 1);
    chk("start_pulse", DW'(op_start), 1);
    chk("model_start", DW'(e_start), 1);
    tick();
    chk("start_1cyc", DW'(op_start), 0);
    rd(2, "opdone_busy", 2);
    chk("model_opdone_busy", e_dout, 2);

    wr(4, 9);
    wr(0, 1);
    chk("no_restart", DW'(op_start), 0);
    chk("operand_held", operand, 5);

    core(0, 120);
    rd(2, "opdone_done", 1);
    chk("irq_rise", DW'(interrupt), 1);
    rd(6, "result_l", 120);
    chk("model_result_l", m_rl, 120);
    rd(5, "result_h", 0);
    core(7, 7);
    rd(6, "result_l_kept", 120);
    wr(6, 77);
    rd(6, "ro_write_ignored", 120);
    wr(3, '1);
    rd(3, "intren_bit0", 1);

    wr(1, 1);
    chk("clear_pulse", DW'(op_clear), 1);
    tick();
    chk("clear_1cyc", DW'(op_clear), 0);
    chk("irq_fall", DW'(interrupt), 0);
    rd(5, "result_h_clr", 0);
    rd(6, "result_l_clr", 0);
    rd(2, "opdone_clr", 0);
    rd(4, "operand_kept", 5);

    wr(0, 2);
    chk("start_bit0_0", DW'(op_start), 0);
    rd(2, "opdone_nostart", 0);

    wr(0, 1);
    s_sel = 1; s_wr = 1; s_addr = {5'd1, 3'd0}; s_din = 1;
    core_done = 1; core_result_l = 720; core_result_h = 3;
    tick();
    idle(); core_done = 0; core_result_l = '0; core_result_h = '0;
    rd(2, "clr_wins_state", 0);
    rd(6, "clr_wins_res", 0);

    rd(0, "opstart_reads0", 0);
    rd(1, "opclear_reads0", 0);

    wr(0, 1);
    rd(2, "busy_again", 2);
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("rst_mid_dout", s_dout, 0);
    chk("rst_mid_operand", operand, 0);
    chk("rst_mid_irq", DW'(interrupt), 0);
    chk("rst_mid_start", DW'(op_start), 0);
    core(1, 24);
    rd(2, "post_rst_opdone", 0);
    rd(6, "post_rst_result", 0);
    rd(3, "post_rst_intren", 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/facto_slave_regs.md
# facto_slave_regs

Parametrised bus-slave register block for the factorial accelerator. It replaces the combinational read-only output mux with a full register interface: writable control registers, a registered read port and start/clear pulse generation. It adds an IDLE/BUSY/DONE sequencer, result capture on core completion and a maskable interrupt. It sits between the bus slave port and the factorial datapath core.

## Interface
- DATA_W, 64, bus data and register width; must be at least 2.
- OFF_W, 8, bus byte-offset width; word index = s_addr[OFF_W-1:3]. Must be at least 6.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- s_sel  in  1  slave select.
- s_wr  in  1  1 = write, 0 = read (qualified by s_sel).
- s_addr  in  OFF_W  byte offset; bits [2:0] ignored.
- s_din  in  DATA_W  write data.
- s_dout  out  DATA_W  registered read data.
- op_start  out  1  one-cycle start pulse to core.
- op_clear  out  1  one-cycle clear pulse to core.
- operand  out  DATA_W  OPERAND register contents.
- core_done  in  1  core completion pulse; results valid in the same cycle.
- core_result_h  in  DATA_W  upper result word.
- core_result_l  in  DATA_W  lower result word.
- interrupt  out  1  registered interrupt = INTREN[0] & done.

## Operation
- Word map:
  - 0 OPSTART: W, bit0=1 requests start; reads 0.
  - 1 OPCLEAR: W, bit0=1 requests clear; reads 0.
  - 2 OPDONE: RO, bit0=done, bit1=busy, other bits 0.
  - 3 INTREN: RW, bit0 only; other bits read 0.
  - 4 OPERAND: RW, full DATA_W.
  - 5 RESULT_H: RO.
  - 6 RESULT_L: RO.
  - Other indices read 0; writes to them and to RO words are ignored.
- States IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE or DONE + start write: go to BUSY. Clears done and pulses op_start.
- BUSY + start write: ignored.
- BUSY + OPERAND write: ignored, so the operand stays stable during computation.
- BUSY + core_done: capture core_result_h/l into RESULT_H/L and go to DONE.
- core_done outside BUSY: ignored; results are not overwritten.
- Clear write in any state: go to IDLE, zero RESULT_H/L, clear done and pulse op_clear. OPERAND and INTREN are kept.
- Clear and core_done in the same cycle: clear wins; nothing is captured.
- A start write with bit0=0 or a clear write with bit0=0 has no effect.

## Timing
- Reset values: s_dout=0, op_start=0, op_clear=0, operand=0, interrupt=0, INTREN=0, RESULT_H/L=0, state IDLE.
- Write accepted at edge N when s_sel & s_wr. Register and state update at N. op_start/op_clear are high for exactly the cycle N..N+1.
- Read: s_sel & ~s_wr sampled at edge N, and s_dout holds the data from N to N+1. Latency is 1 cycle.
- s_dout is 0 in any cycle following a non-read.
- A read in the same cycle as a state-changing event returns the pre-edge value.
- interrupt is registered. It rises at the edge after DONE is entered (or INTREN is set while in DONE), and falls at the edge after a start, a clear or INTREN being cleared.
- Reset asserted mid-operation: all state returns to reset values at that edge; an in-flight core_done is ignored.
- Back-to-back accesses every cycle are supported with no wait states.

## Test plan
- Reset, then read word 2 -> s_dout=0 one cycle later; read word 7 -> 0; interrupt=0.
- Write OPERAND=5, INTREN=1, OPSTART=1 -> op_start high for 1 cycle and OPDONE reads 0x2. Then assert core_done with result_h=0, result_l=120 -> OPDONE=0x1, RESULT_L=120, and interrupt rises one cycle later.
- While BUSY, write OPERAND=9 and OPSTART=1 -> operand stays 5 and no second op_start pulse.
- In DONE, write OPCLEAR=1 -> op_clear pulses and interrupt falls. RESULT_H/L read 0, OPDONE reads 0, OPERAND still 5.
- Assert core_done and a clear write in the same cycle while BUSY -> state IDLE and RESULT_L stays 0.
- Assert reset_n=0 for one cycle while BUSY -> all outputs 0. A subsequent core_done is ignored and OPDONE reads 0.
